rvga_icache: RTL and testbench

RVGA_ICACHE -- requirements
Module: rvga_icache

---
 rtl/rvga_icache.sv | 179 +++++++++++++++++
 tb/tb_rvga_icache.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_icache.sv
`default_nettype none
// ============================================================================
//  Module   : rvga_icache
//  Purpose  : Direct-mapped, read-only instruction cache. It serves one CPU
//             fetch at a time. On a miss it refills the whole indexed line
//             from instruction memory, always starting at word 0.
//  Ports    : clk, rst               - clock and synchronous active-high reset
//             cpu_addr/cpu_read      - fetch request (held until cpu_resp)
//             cpu_rdata/cpu_resp     - fetched word plus a one-cycle completion pulse
//             icache_iddr_addr/read  - refill request (held until a response)
//             iddr_icache_rdata/resp - refill data plus a one-cycle word completion
//  Revision : 1.0 - initial release
// ============================================================================
module rvga_icache #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_read,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic [31:0] icache_iddr_addr,
    output logic        icache_iddr_read,
    input  logic [31:0] iddr_icache_rdata,
    input  logic        iddr_icache_resp
);

    // Address split: [1:0] byte | [c_W+1:2] word | index | tag
    localparam int c_W     = $clog2(WORDS_PER_LINE);
    localparam int c_I     = $clog2(NUM_LINES);
    localparam int c_T     = 32 - c_W - c_I - 2;
    localparam int c_DEPTH = NUM_LINES * WORDS_PER_LINE;
    localparam logic [c_W-1:0] c_LAST = c_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [c_T-1:0]      r_tag  [NUM_LINES];
    logic [31:0]         r_data [c_DEPTH];
    logic [c_W-1:0]      r_cnt;

    // Captured request, so the refill does not depend on cpu_addr staying put
    logic [c_T-1:0]      r_req_tag;
    logic [c_I-1:0]      r_req_idx;
    logic [c_W-1:0]      r_req_word;

    logic                r_cpu_resp;
    logic [31:0]         r_cpu_rdata;
    logic                r_iddr_read;
    logic [31:0]         r_iddr_addr;

    logic [c_T-1:0]      w_tag;
    logic [c_I-1:0]      w_idx;
    logic [c_W-1:0]      w_word;
    logic                w_hit;
    logic [31:0]         w_hit_data;
    logic [31:0]         w_req_data;
    logic                w_fill_last;
    logic                w_fill_we;
    logic [c_W-1:0]      w_cnt_next;
    logic                w_unused_byte_bits;

    assign w_tag      = cpu_addr[31 -: c_T];
    assign w_idx      = cpu_addr[c_W+2 +: c_I];
    assign w_word     = cpu_addr[2 +: c_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_data = r_data[{w_idx, w_word}];
    assign w_req_data = r_data[{r_req_idx, r_req_word}];

    assign w_fill_last = (r_cnt == c_LAST);
    assign w_cnt_next  = r_cnt + 1'b1;
    // Responses are only accepted while refilling; anything else is dropped
    assign w_fill_we   = (r_state == S_FILL) && iddr_icache_resp && !rst;

    // Byte offset within a word does not affect an instruction fetch
    assign w_unused_byte_bits = ^cpu_addr[1:0];

    // ------------------------------------------------------------------------
    // Data and tag storage: no reset, validity is tracked by r_valid only
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{r_req_idx, r_cnt}] <= iddr_icache_rdata;
            if (w_fill_last) begin
                r_tag[r_req_idx] <= r_req_tag;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_req_tag   <= '0;
            r_req_idx   <= '0;
            r_req_word  <= '0;
            r_cpu_resp  <= 1'b0;
            r_cpu_rdata <= '0;
            r_iddr_read <= 1'b0;
            r_iddr_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_read) begin
                        r_req_tag  <= w_tag;
                        r_req_idx  <= w_idx;
                        r_req_word <= w_word;
                        if (w_hit) begin
                            r_state     <= S_RESP;
                            r_cpu_resp  <= 1'b1;
                            r_cpu_rdata <= w_hit_data;
                        end else begin
                            // The line is invalidated first so that a refill
                            // cut short never leaves a half-written valid line.
                            r_state        <= S_FILL;
                            r_cnt          <= '0;
                            r_valid[w_idx] <= 1'b0;
                            r_iddr_read    <= 1'b1;
                            r_iddr_addr    <= {w_tag, w_idx, {c_W{1'b0}}, 2'b00};
                        end
                    end
                end

                S_FILL: begin
                    if (iddr_icache_resp) begin
                        if (w_fill_last) begin
                            r_state            <= S_RESP;
                            r_valid[r_req_idx] <= 1'b1;
                            r_cnt              <= '0;
                            r_iddr_read        <= 1'b0;
                            r_iddr_addr        <= '0;
                            r_cpu_resp         <= 1'b1;
                            // The requested word may be arriving on this very
                            // edge, in which case the array is not yet written.
                            r_cpu_rdata        <= (r_req_word == c_LAST) ?
                                                  iddr_icache_rdata : w_req_data;
                        end else begin
                            r_cnt       <= w_cnt_next;
                            r_iddr_addr <= {r_req_tag, r_req_idx, w_cnt_next, 2'b00};
                        end
                    end
                end

                S_RESP: begin
                    // cpu_read is still high here and is deliberately ignored
                    r_state     <= S_IDLE;
                    r_cpu_resp  <= 1'b0;
                    r_cpu_rdata <= '0;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cpu_resp  <= 1'b0;
                    r_cpu_rdata <= '0;
                    r_iddr_read <= 1'b0;
                    r_iddr_addr <= '0;
                end
            endcase
        end
    end

    assign cpu_resp         = r_cpu_resp;
    assign cpu_rdata        = r_cpu_rdata;
    assign icache_iddr_read = r_iddr_read;
    assign icache_iddr_addr = r_iddr_addr;

endmodule
`default_nettype wire

// File: tb/tb_rvga_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvga_icache
//  Purpose  : Self-checking bench for rvga_icache. An instruction memory
//             returns addr+0x1000 with a programmable latency. A line-level
//             reference cache predicts hit/miss, latency, data and the
//             refill address sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvga_icache;

    localparam int TB_LINES = 16;
    localparam int TB_WORDS = 4;
    localparam int TB_W     = $clog2(TB_WORDS);
    localparam int TB_I     = $clog2(TB_LINES);

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_read;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic [31:0] icache_iddr_addr;
    logic        icache_iddr_read;
    logic [31:0] iddr_icache_rdata;
    logic        iddr_icache_resp;

    rvga_icache #(
        .NUM_LINES      (TB_LINES),
        .WORDS_PER_LINE (TB_WORDS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_addr          (cpu_addr),
        .cpu_read          (cpu_read),
        .cpu_rdata         (cpu_rdata),
        .cpu_resp          (cpu_resp),
        .icache_iddr_addr  (icache_iddr_addr),
        .icache_iddr_read  (icache_iddr_read),
        .iddr_icache_rdata (iddr_icache_rdata),
        .iddr_icache_resp  (iddr_icache_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference cache: per line a valid flag and the full tag
    bit          m_valid [TB_LINES];
    logic [31:0] m_tag   [TB_LINES];

    // Memory responder controls and refill log
    int          mem_lat   = 2;
    int          spur_req  = 0;
    int          spur_done = 0;
    logic [31:0] refill_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Instruction memory: a word request answered once read has been high
    // for mem_lat cycles; spurious pulses are injected only while idle.
    initial begin : g_mem
        int word_cycles;
        word_cycles       = 0;
        iddr_icache_resp  = 1'b0;
        iddr_icache_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            iddr_icache_resp  = 1'b0;
            iddr_icache_rdata = '0;
            if (icache_iddr_read) begin
                word_cycles++;
                if (word_cycles >= mem_lat) begin
                    iddr_icache_resp  = 1'b1;
                    iddr_icache_rdata = icache_iddr_addr + 32'h1000;
                    refill_log.push_back(icache_iddr_addr);
                    word_cycles = 0;
                end
            end else begin
                word_cycles = 0;
                if (spur_req != spur_done) begin
                    spur_done         = spur_req;
                    iddr_icache_resp  = 1'b1;
                    iddr_icache_rdata = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic model_invalidate();
        for (int i = 0; i < TB_LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int lat);
        int          idx;
        logic [31:0] tagv;
        logic [31:0] base;
        logic [31:0] line_mask;
        bit          hit;
        int          start;
        int          n;
        int          got_cnt;
        idx       = int'((addr >> (TB_W + 2)) % TB_LINES);
        tagv      = addr >> (TB_W + TB_I + 2);
        line_mask = 32'(TB_WORDS * 4 - 1);
        base      = addr & ~line_mask;
        hit       = m_valid[idx] && (m_tag[idx] == tagv);
        mem_lat   = lat;
        start     = refill_log.size();

        @(negedge clk);
        cpu_addr = addr;
        cpu_read = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!cpu_resp) check("rdata_while_busy", cpu_rdata, 32'h0);
        end while (!cpu_resp && n < 200);

        check("latency", 32'(n), hit ? 32'd1 : 32'(TB_WORDS * lat + 1));
        check("rdata", cpu_rdata, (addr & ~32'h3) + 32'h1000);
        check("iddr_read_in_resp", {31'b0, icache_iddr_read}, 32'h0);
        got_cnt = refill_log.size() - start;
        check("refill_count", 32'(got_cnt), hit ? 32'd0 : 32'(TB_WORDS));
        if (!hit) begin
            for (int k = 0; k < TB_WORDS && k < got_cnt; k++)
                check("refill_addr", refill_log[start + k], base + 32'(4 * k));
        end
        cpu_read = 1'b0;

        @(negedge clk);
        check("resp_one_cycle", {31'b0, cpu_resp}, 32'h0);
        check("rdata_zero_after", cpu_rdata, 32'h0);
        check("iddr_addr_idle", icache_iddr_addr, 32'h0);

        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tagv;
        end
    endtask

    task automatic spurious();
        spur_req++;
        repeat (3) begin
            @(negedge clk);
            check("spurious_no_resp", {31'b0, cpu_resp}, 32'h0);
        end
        check("spurious_no_read", {31'b0, icache_iddr_read}, 32'h0);
    endtask

    initial begin : g_main
        int          start;
        int          n;
        logic [31:0] a;
        rst      = 1'b1;
        cpu_addr = '0;
        cpu_read = 1'b0;
        model_invalidate();
        repeat (3) @(negedge clk);
        check("rst_resp", {31'b0, cpu_resp}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_iddr_read", {31'b0, icache_iddr_read}, 32'h0);
        check("rst_iddr_addr", icache_iddr_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, hit, byte offset, conflict
        do_fetch(32'h0000_0108, 2);
        do_fetch(32'h0000_010C, 2);
        do_fetch(32'h0000_0208, 2);
        do_fetch(32'h0000_0108, 2);

        // Spurious response while idle must not disturb the line
        spurious();
        do_fetch(32'h0000_0104, 2);
        do_fetch(32'h0000_010B, 2);

        // Reset after the second refill word of a conflicting miss
        mem_lat = 2;
        start   = refill_log.size();
        @(negedge clk);
        cpu_addr = 32'h0000_0208;
        cpu_read = 1'b1;
        n = 0;
        while (refill_log.size() < start + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midfill_reached", 32'(refill_log.size() - start), 32'd2);
        @(negedge clk);
        rst      = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midfill_iddr_read", {31'b0, icache_iddr_read}, 32'h0);
        check("midfill_iddr_addr", icache_iddr_addr, 32'h0);
        check("midfill_resp", {31'b0, cpu_resp}, 32'h0);
        model_invalidate();
        do_fetch(32'h0000_0108, 2);
        do_fetch(32'h0000_0208, 2);

        // Randomized traffic over a few tags and indices to force conflicts
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) spurious();
            a = (32'($urandom_range(1, 3)) << 8) |
                (32'($urandom_range(0, 3)) << 4) |
                 32'($urandom_range(0, 15));
            do_fetch(a, int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : g_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
